soc_system_nios_cmd_fifo: RTL and testbench

//   Synchronous FIFO that buffers command words from fabric logic until the Nios reads them.

---
 rtl/soc_system_nios_fifo_pkg.sv | 13 +
 rtl/soc_system_nios_fifo_ram.sv | 23 ++
 rtl/soc_system_nios_cmd_fifo.sv | 143 ++++++++++++++
 tb/tb_soc_system_nios_cmd_fifo.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/soc_system_nios_fifo_pkg.sv
// rtl/soc_system_nios_fifo_pkg.sv - shared register map constants for the Nios command FIFO
package soc_system_nios_fifo_pkg;

  // Avalon word addresses
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  // Register bit positions
  localparam int STATUS_OVF_BIT = 31;
  localparam int CTRL_FLUSH_BIT = 0;

endpackage

// File: rtl/soc_system_nios_fifo_ram.sv
// rtl/soc_system_nios_fifo_ram.sv - register-array storage, sync write / async read
module soc_system_nios_fifo_ram #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // Storage is deliberately not reset; stale words are never observable
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/soc_system_nios_cmd_fifo.sv
// rtl/soc_system_nios_cmd_fifo.sv - fabric-to-Nios command FIFO with Avalon-MM drain port (option: NIOS_FIFO_STATUS_EN)
module soc_system_nios_cmd_fifo
  import soc_system_nios_fifo_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              not_empty,
  output logic              full
);

  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(2 ** DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = (DEPTH_LOG2)'(1);

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [31:0]           rdata_q, rdata_d;

  logic              flush;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] ram_rdata;
  logic [31:0]       data_word;
  logic [31:0]       status_word;
  logic              unused_ok;

  // Only a few writedata bits are decoded
  assign unused_ok = ^avs_writedata;

  assign flush     = avs_write && (avs_address == ADDR_CTRL) && avs_writedata[CTRL_FLUSH_BIT];
  assign full      = (count_q == DEPTH_CNT);
  assign not_empty = (count_q != '0);
  // No pass-through when full, and a flush cycle refuses the producer
  assign wr_ready  = !full && !flush;
  assign push      = wr_valid && wr_ready;
  assign pop       = avs_read && (avs_address == ADDR_DATA) && not_empty;

  soc_system_nios_fifo_ram #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // Zero-extend the stored word onto the 32-bit bus
  always_comb begin
    data_word = '0;
    data_word[DATA_W-1:0] = ram_rdata;
  end

`ifdef NIOS_FIFO_STATUS_EN
  logic ovf_q, ovf_d;

  // Sticky overflow: set on any offer while full, cleared by firmware; set wins
  always_comb begin
    ovf_d = ovf_q;
    if (avs_write && (avs_address == ADDR_STATUS) && avs_writedata[STATUS_OVF_BIT]) ovf_d = 1'b0;
    if (wr_valid && full) ovf_d = 1'b1;
  end

  // Overflow flag register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  // STATUS layout: overflow in the top bit, occupancy in the low bits
  always_comb begin
    status_word = '0;
    status_word[DEPTH_LOG2:0]   = count_q;
    status_word[STATUS_OVF_BIT] = ovf_q;
  end
`else
  assign status_word = '0;
`endif

  // Pointer and occupancy update; flush overrides any concurrent pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Read data mux; the register holds its value between reads
  always_comb begin
    rdata_d = rdata_q;
    if (avs_read) begin
      case (avs_address)
        ADDR_DATA:   rdata_d = pop ? data_word : 32'd0;
        ADDR_STATUS: rdata_d = status_word;
        default:     rdata_d = 32'd0;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end

  assign avs_readdata = rdata_q;

endmodule

// File: tb/tb_soc_system_nios_cmd_fifo.sv
// tb/tb_soc_system_nios_cmd_fifo.sv - directed self-checking bench for the Nios command FIFO
module tb_soc_system_nios_cmd_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        not_empty;
  logic        full;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [31:0] model_q[$];

  soc_system_nios_cmd_fifo #(.DATA_W(32), .DEPTH_LOG2(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .not_empty     (not_empty),
    .full          (full)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_valid = 0; wr_data = 0; avs_read = 0; avs_write = 0;
    avs_address = 0; avs_writedata = 0;
  endtask

  task automatic do_push(input logic [31:0] d);
    wr_data = d; wr_valid = 1; step(); wr_valid = 0;
  endtask

  task automatic do_read(input logic [1:0] a);
    avs_address = a; avs_read = 1; step(); avs_read = 0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1; step(); avs_write = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    step(); step();
    chk_cnt++; if (not_empty !== 1'b0) $display("FAIL reset_not_empty got=%b exp=0", not_empty); else pass_cnt++;
    chk_cnt++; if (full !== 1'b0) $display("FAIL reset_full got=%b exp=0", full); else pass_cnt++;
    chk_cnt++; if (avs_readdata !== 32'd0) $display("FAIL reset_readdata got=%h exp=0", avs_readdata); else pass_cnt++;
    reset = 0;
    step();
    chk_cnt++; if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); else pass_cnt++;
  endtask

  task automatic test_single();
    do_push(32'hA5);
    chk_cnt++; if (not_empty !== 1'b1) $display("FAIL single_not_empty got=%b exp=1", not_empty); else pass_cnt++;
    do_read(2'd0);
    chk_cnt++; if (avs_readdata !== 32'hA5) $display("FAIL single_data got=%h exp=a5", avs_readdata); else pass_cnt++;
    chk_cnt++; if (not_empty !== 1'b0) $display("FAIL single_empty_after got=%b exp=0", not_empty); else pass_cnt++;
    step();
    chk_cnt++; if (avs_readdata !== 32'hA5) $display("FAIL single_hold got=%h exp=a5", avs_readdata); else pass_cnt++;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      chk_cnt++; if (wr_ready !== 1'b1) $display("FAIL fill_ready_%0d got=%b exp=1", i, wr_ready); else pass_cnt++;
      do_push(32'(i));
    end
    chk_cnt++; if (full !== 1'b1) $display("FAIL fill_full got=%b exp=1", full); else pass_cnt++;
    chk_cnt++; if (wr_ready !== 1'b0) $display("FAIL fill_wr_ready got=%b exp=0", wr_ready); else pass_cnt++;
    do_push(32'h99);
    chk_cnt++; if (full !== 1'b1) $display("FAIL fill_17th_full got=%b exp=1", full); else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      do_read(2'd0);
      chk_cnt++; if (avs_readdata !== 32'(i)) $display("FAIL drain_%0d got=%h exp=%h", i, avs_readdata, i); else pass_cnt++;
    end
    chk_cnt++; if (not_empty !== 1'b0) $display("FAIL drain_empty got=%b exp=0", not_empty); else pass_cnt++;
    chk_cnt++; if (full !== 1'b0) $display("FAIL drain_not_full got=%b exp=0", full); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic        p, r, exp_pop;
    logic [31:0] d, expv;
    do_push(32'h10); do_push(32'h11); do_push(32'h12);
    wr_data = 32'h13; wr_valid = 1; avs_address = 2'd0; avs_read = 1;
    step();
    wr_valid = 0; avs_read = 0;
    chk_cnt++; if (avs_readdata !== 32'h10) $display("FAIL b2b_first got=%h exp=10", avs_readdata); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      do_read(2'd0);
      chk_cnt++; if (avs_readdata !== 32'h11 + 32'(i)) $display("FAIL b2b_drain_%0d got=%h exp=%h", i, avs_readdata, 32'h11 + 32'(i)); else pass_cnt++;
    end
    chk_cnt++; if (not_empty !== 1'b0) $display("FAIL b2b_count3 got=%b exp=0", not_empty); else pass_cnt++;
    model_q.delete();
    for (int i = 0; i < 30; i++) begin
      p = (i % 3) != 2;
      r = (i % 3) != 0;
      d = 32'h100 + 32'(i);
      exp_pop = r && (model_q.size() != 0);
      expv = exp_pop ? model_q[0] : 32'd0;
      wr_valid = p; wr_data = d; avs_address = 2'd0; avs_read = r;
      #1;
      if (p) begin
        chk_cnt++; if (wr_ready !== 1'b1) $display("FAIL mix_ready_%0d got=%b exp=1", i, wr_ready); else pass_cnt++;
      end
      step();
      wr_valid = 0; avs_read = 0;
      if (exp_pop) void'(model_q.pop_front());
      if (p) model_q.push_back(d);
      if (r) begin
        chk_cnt++; if (avs_readdata !== expv) $display("FAIL mix_data_%0d got=%h exp=%h", i, avs_readdata, expv); else pass_cnt++;
      end
      chk_cnt++; if (not_empty !== (model_q.size() != 0)) $display("FAIL mix_not_empty_%0d got=%b exp=%b", i, not_empty, model_q.size() != 0); else pass_cnt++;
    end
    while (model_q.size() != 0) begin
      expv = model_q.pop_front();
      do_read(2'd0);
      chk_cnt++; if (avs_readdata !== expv) $display("FAIL mix_drain got=%h exp=%h", avs_readdata, expv); else pass_cnt++;
    end
    chk_cnt++; if (not_empty !== 1'b0) $display("FAIL mix_empty got=%b exp=0", not_empty); else pass_cnt++;
  endtask

  task automatic test_empty_read();
    do_read(2'd0);
    chk_cnt++; if (avs_readdata !== 32'd0) $display("FAIL empty_read got=%h exp=0", avs_readdata); else pass_cnt++;
    wr_data = 32'h1234; wr_valid = 1; avs_address = 2'd0; avs_read = 1;
    step();
    wr_valid = 0; avs_read = 0;
    chk_cnt++; if (avs_readdata !== 32'd0) $display("FAIL empty_push_read got=%h exp=0", avs_readdata); else pass_cnt++;
    chk_cnt++; if (not_empty !== 1'b1) $display("FAIL empty_push_kept got=%b exp=1", not_empty); else pass_cnt++;
    do_write(2'd0, 32'hDEAD);
    chk_cnt++; if (not_empty !== 1'b1) $display("FAIL data_write_ignored got=%b exp=1", not_empty); else pass_cnt++;
    do_read(2'd0);
    chk_cnt++; if (avs_readdata !== 32'h1234) $display("FAIL empty_then_data got=%h exp=1234", avs_readdata); else pass_cnt++;
    chk_cnt++; if (not_empty !== 1'b0) $display("FAIL empty_final got=%b exp=0", not_empty); else pass_cnt++;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) do_push(32'h50 + 32'(i));
    wr_valid = 1; wr_data = 32'h77;
    avs_address = 2'd2; avs_writedata = 32'd1; avs_write = 1;
    #1;
    chk_cnt++; if (wr_ready !== 1'b0) $display("FAIL flush_wr_ready got=%b exp=0", wr_ready); else pass_cnt++;
    step();
    wr_valid = 0; avs_write = 0;
    chk_cnt++; if (not_empty !== 1'b0) $display("FAIL flush_not_empty got=%b exp=0", not_empty); else pass_cnt++;
    do_read(2'd0);
    chk_cnt++; if (avs_readdata !== 32'd0) $display("FAIL flush_read got=%h exp=0", avs_readdata); else pass_cnt++;
    do_push(32'h55);
    do_read(2'd0);
    chk_cnt++; if (avs_readdata !== 32'h55) $display("FAIL flush_reuse got=%h exp=55", avs_readdata); else pass_cnt++;
    do_read(2'd2);
    chk_cnt++; if (avs_readdata !== 32'd0) $display("FAIL ctrl_read got=%h exp=0", avs_readdata); else pass_cnt++;
  endtask

  task automatic test_status();
    logic [31:0] exp_full, exp_clr;
`ifdef NIOS_FIFO_STATUS_EN
    exp_full = 32'h8000_0010;
    exp_clr  = 32'h0000_0010;
`else
    exp_full = 32'd0;
    exp_clr  = 32'd0;
`endif
    do_push(32'hAA);
    reset = 1;
    #2;
    chk_cnt++; if (not_empty !== 1'b0) $display("FAIL midreset_not_empty got=%b exp=0", not_empty); else pass_cnt++;
    step();
    reset = 0;
    step();
    for (int i = 0; i < 16; i++) do_push(32'h200 + 32'(i));
    do_push(32'h999);
    do_read(2'd1);
    chk_cnt++; if (avs_readdata !== exp_full) $display("FAIL status_ovf got=%h exp=%h", avs_readdata, exp_full); else pass_cnt++;
    do_write(2'd1, 32'h8000_0000);
    do_read(2'd1);
    chk_cnt++; if (avs_readdata !== exp_clr) $display("FAIL status_clr got=%h exp=%h", avs_readdata, exp_clr); else pass_cnt++;
    do_read(2'd3);
    chk_cnt++; if (avs_readdata !== 32'd0) $display("FAIL reserved_read got=%h exp=0", avs_readdata); else pass_cnt++;
    do_read(2'd0);
    chk_cnt++; if (avs_readdata !== 32'h200) $display("FAIL post_status_data got=%h exp=200", avs_readdata); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_back_to_back();
    test_empty_read();
    test_flush();
    test_status();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
